mfcc_sequencer: RTL and testbench
=================================

MFCC_SEQUENCER -- requirements
Module: mfcc_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000: maximum number of cycles allowed in any one processing state.
REQ-002 SHALL have parameter FRAME_CNT_WIDTH, default 16: width of the frame counter.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i, input, 1: run request (level).
REQ-006 SHALL have port stop_i, input, 1: stop after the current frame (pulse).
REQ-007 SHALL have port clear_i, input, 1: clear the error state (pulse).
REQ-008 SHALL have port window_start_i, input, 1: window buffer holds a full frame (pulse).
REQ-009 SHALL have ports hamming_done_i, fft_done_i, mel_done_i and dct_done_i, each input, 1: stage-done pulses.
REQ-010 SHALL have port out_ready_i, input, 1: consumer accepts the coefficient frame.
REQ-011 SHALL have port start_move_o, output, 1: one-cycle pulse that advances the window buffer by the frame move.
REQ-012 SHALL have port frame_valid_o, output, 1: coefficient frame is complete and stable.
REQ-013 SHALL have port frame_count_o, output, FRAME_CNT_WIDTH: number of frames accepted by the consumer.
REQ-014 SHALL have port busy_o, output, 1: a frame is in flight.
REQ-015 SHALL have port idle_o, output, 1: FSM is in IDLE.
REQ-016 SHALL have port error_o, output, 1: sticky fault flag.
REQ-017 SHALL have port state_o, output, 3: current FSM state encoding, for debug.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT_WIN, HAMMING, FFT, MEL, DCT, OUTPUT and ERROR, with one frame in flight at a time.
REQ-019 IDLE SHALL go to WAIT_WIN when enable_i=1 and error_o=0.
REQ-020 WAIT_WIN SHALL go to HAMMING on window_start_i; it SHALL go to IDLE if enable_i=0 or a stop is pending.
REQ-021 HAMMING SHALL go to FFT on hamming_done_i, and start_move_o SHALL pulse for exactly 1 cycle, registered (the cycle after hamming_done_i is sampled).
REQ-022 The remaining stage transitions SHALL be: FFT->MEL on fft_done_i, MEL->DCT on mel_done_i, DCT->OUTPUT on dct_done_i.
REQ-023 OUTPUT SHALL hold frame_valid_o=1 until out_ready_i=1.
REQ-024 On the accepting cycle, frame_count_o SHALL increment (saturating at all-ones) and frame_valid_o SHALL drop the next cycle.
REQ-025 After acceptance, the FSM SHALL go to WAIT_WIN if enable_i=1 and no stop is pending, otherwise to IDLE.
REQ-026 busy_o SHALL be 1 in HAMMING, FFT, MEL, DCT and OUTPUT; idle_o SHALL be 1 only in IDLE.
REQ-027 stop_i SHALL set stop_pending in any state; stop_pending SHALL clear on entry to IDLE, and the current frame SHALL always complete.
REQ-028 A done pulse for any stage other than the one expected in the current state SHALL go to ERROR; done pulses in IDLE and WAIT_WIN SHALL be ignored.
REQ-029 Simultaneous done pulses in which the expected one is present SHALL take the expected transition and ignore the others.
REQ-030 The watchdog counter SHALL reset on every state change and count in HAMMING, FFT, MEL and DCT; reaching TIMEOUT_CYCLES SHALL go to ERROR.
REQ-031 The watchdog SHALL NOT count in OUTPUT, so the consumer may stall indefinitely.
REQ-032 ERROR SHALL set error_o=1 and deassert busy_o and frame_valid_o.
REQ-033 clear_i in ERROR SHALL go to IDLE and clear error_o and stop_pending; frame_count_o SHALL be retained.
REQ-034 clear_i in any other state SHALL be ignored.
REQ-035 If clear_i and a fault occur in the same cycle, the fault SHALL take priority.

Reset
REQ-036 Asserting rst_n=0 SHALL asynchronously force the state to IDLE and clear the watchdog and stop_pending, including mid-frame.
REQ-037 During reset all outputs SHALL be 0 except idle_o=1 and state_o=IDLE encoding.
REQ-038 The first transition after reset deassertion SHALL occur no earlier than the first rising edge of clk.

Structure
REQ-039 The state enum (3-bit) and the default TIMEOUT_CYCLES constant SHALL live in the shared package mfcc_pkg.
REQ-040 The watchdog SHALL be a sub-module stage_watchdog (inputs clear and count_en; output expired).
REQ-041 All outputs SHALL be registered, with no combinational input-to-output path.

Verification
REQ-042 enable_i=1; window_start, then hamming, fft, mel and dct done pulses each 10 cycles apart; out_ready_i=1 -> exactly one start_move_o pulse 1 cycle after hamming_done_i, frame_valid_o for 1 cycle, frame_count_o=1, state returns to WAIT_WIN.
REQ-043 Three back-to-back frames with out_ready_i=0 for 50 cycles in frame 2 -> frame_valid_o held for 50 cycles, no error, final frame_count_o=3.
REQ-044 stop_i pulsed during FFT of frame 1 -> frame completes, frame_count_o=1, FSM goes to IDLE, idle_o=1, later window_start_i ignored.
REQ-045 TIMEOUT_CYCLES=100 with fft_done_i withheld -> error_o=1 exactly 100 cycles after FFT entry; clear_i -> IDLE, error_o=0, frame_count_o unchanged.
REQ-046 mel_done_i pulsed while in HAMMING -> ERROR next cycle, start_move_o never asserted.
REQ-047 rst_n=0 for 3 cycles while in MEL -> immediate IDLE, all outputs at reset values; after release with enable_i=1 -> WAIT_WIN.

Source files
------------

// File: rtl/mfcc_pkg.sv
// Shared state encoding and constants for the MFCC frame sequencer.
package mfcc_pkg;

   localparam int DEFAULT_TIMEOUT_CYCLES = 20000;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_WIN = 3'd1,
      ST_HAMMING  = 3'd2,
      ST_FFT      = 3'd3,
      ST_MEL      = 3'd4,
      ST_DCT      = 3'd5,
      ST_OUTPUT   = 3'd6,
      ST_ERROR    = 3'd7
   } state_e;

   // Done bits are ordered {dct, mel, fft, hamming}; returns the bit a stage state waits on.
   function automatic logic [3:0] stage_done_mask(state_e s);
      logic [3:0] m;
      m = 4'b0000;
      case (s)
         ST_HAMMING: m = 4'b0001;
         ST_FFT:     m = 4'b0010;
         ST_MEL:     m = 4'b0100;
         ST_DCT:     m = 4'b1000;
         default:    m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mfcc_sequencer_if.sv
// Control/status bundle between the MFCC processing pipeline and its frame sequencer.
interface mfcc_sequencer_if #(
   parameter int FRAME_CNT_WIDTH = 16
);

   logic                       enable_i;
   logic                       stop_i;
   logic                       clear_i;
   logic                       window_start_i;
   logic                       hamming_done_i;
   logic                       fft_done_i;
   logic                       mel_done_i;
   logic                       dct_done_i;
   logic                       out_ready_i;
   logic                       start_move_o;
   logic                       frame_valid_o;
   logic [FRAME_CNT_WIDTH-1:0] frame_count_o;
   logic                       busy_o;
   logic                       idle_o;
   logic                       error_o;
   logic [2:0]                 state_o;

   // Handshake: a coefficient frame transfers on a cycle where frame_valid_o and
   // out_ready_i are both 1; frame_valid_o stays high and stable until then.
   modport master (
      output enable_i, stop_i, clear_i, window_start_i,
      output hamming_done_i, fft_done_i, mel_done_i, dct_done_i, out_ready_i,
      input  start_move_o, frame_valid_o, frame_count_o, busy_o, idle_o, error_o, state_o
   );

   modport slave (
      input  enable_i, stop_i, clear_i, window_start_i,
      input  hamming_done_i, fft_done_i, mel_done_i, dct_done_i, out_ready_i,
      output start_move_o, frame_valid_o, frame_count_o, busy_o, idle_o, error_o, state_o
   );

endinterface

// File: rtl/stage_watchdog.sv
// Per-state cycle budget: restarts on every state change, flags when the budget is used up.
module stage_watchdog
   import mfcc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q, count_d;

   // Expiry is raised during the last allowed cycle so the owner leaves on the budget edge.
   assign expired = count_en && (count_q == LIMIT);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_en && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mfcc_sequencer.sv
// Frame sequencer for the MFCC pipeline: walks one frame through the window,
// hamming, FFT, mel and DCT stages, hands it to the consumer and guards each stage.
module mfcc_sequencer
   import mfcc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input logic             clk,
   input logic             rst_n,
   mfcc_sequencer_if.slave bus
);

   state_e                     state_q, state_d;
   logic                       stop_pending_q, stop_pending_d;
   logic                       start_move_q, start_move_d;
   logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;

   logic [3:0] done_vec, done_mask;
   logic       expected_done, stray_done, stop_seen;
   logic       wd_clear, wd_count_en, wd_expired;
   logic       busy_s, idle_s, error_s, valid_s;

   assign done_vec      = {bus.dct_done_i, bus.mel_done_i, bus.fft_done_i, bus.hamming_done_i};
   assign done_mask     = stage_done_mask(state_q);
   assign expected_done = |(done_vec & done_mask);
   assign stray_done    = |(done_vec & ~done_mask);
   assign stop_seen     = stop_pending_q | bus.stop_i;

   assign wd_count_en = (state_q == ST_HAMMING) || (state_q == ST_FFT) ||
                        (state_q == ST_MEL)     || (state_q == ST_DCT);
   assign wd_clear    = (state_d != state_q);

   stage_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (wd_clear),
      .count_en (wd_count_en),
      .expired  (wd_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // An expected done wins over stray dones and over expiry in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.enable_i) state_d = ST_WAIT_WIN;
         end
         ST_WAIT_WIN: begin
            if (!bus.enable_i || stop_seen) state_d = ST_IDLE;
            else if (bus.window_start_i)    state_d = ST_HAMMING;
         end
         ST_HAMMING, ST_FFT, ST_MEL, ST_DCT: begin
            if (expected_done) begin
               case (state_q)
                  ST_HAMMING: state_d = ST_FFT;
                  ST_FFT:     state_d = ST_MEL;
                  ST_MEL:     state_d = ST_DCT;
                  default:    state_d = ST_OUTPUT;
               endcase
            end else if (stray_done || wd_expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_OUTPUT: begin
            if (bus.out_ready_i) begin
               state_d = (bus.enable_i && !stop_seen) ? ST_WAIT_WIN : ST_IDLE;
            end
         end
         ST_ERROR: begin
            if (bus.clear_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_s  = 1'b0;
      idle_s  = 1'b0;
      error_s = 1'b0;
      valid_s = 1'b0;
      case (state_q)
         ST_IDLE:                            idle_s  = 1'b1;
         ST_HAMMING, ST_FFT, ST_MEL, ST_DCT: busy_s  = 1'b1;
         ST_OUTPUT: begin
            busy_s  = 1'b1;
            valid_s = 1'b1;
         end
         ST_ERROR:                           error_s = 1'b1;
         default: ;
      endcase
   end

   // Stop requests persist until the sequencer actually lands in IDLE.
   always_comb begin
      start_move_d   = (state_q == ST_HAMMING) && bus.hamming_done_i;
      frame_count_d  = frame_count_q;
      if ((state_q == ST_OUTPUT) && bus.out_ready_i && (frame_count_q != '1)) begin
         frame_count_d = frame_count_q + 1'b1;
      end
      stop_pending_d = stop_pending_q | bus.stop_i;
      if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
         stop_pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stop_pending_q <= 1'b0;
         start_move_q   <= 1'b0;
         frame_count_q  <= '0;
      end else begin
         stop_pending_q <= stop_pending_d;
         start_move_q   <= start_move_d;
         frame_count_q  <= frame_count_d;
      end
   end

   assign bus.state_o       = state_q;
   assign bus.start_move_o  = start_move_q;
   assign bus.frame_count_o = frame_count_q;
   assign bus.busy_o        = busy_s;
   assign bus.idle_o        = idle_s;
   assign bus.error_o       = error_s;
   assign bus.frame_valid_o = valid_s;

endmodule

// File: tb/tb_mfcc_sequencer.sv
// Directed bench for mfcc_sequencer: single frames, stalls, stop, timeout, stray dones, reset.
`timescale 1ns/1ps
module tb_mfcc_sequencer;
   import mfcc_pkg::*;

   localparam int TO = 100;
   localparam int P_WIN = 0, P_HAM = 1, P_FFT = 2, P_MEL = 3, P_DCT = 4, P_STOP = 5, P_CLR = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int passed = 0;
   int move_cnt = 0;
   int valid_cnt = 0;
   int model_cnt = 0;
   logic [15:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   mfcc_sequencer_if #(.FRAME_CNT_WIDTH(16)) bus ();

   mfcc_sequencer #(
      .TIMEOUT_CYCLES  (TO),
      .FRAME_CNT_WIDTH (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(negedge clk) begin
      if (bus.start_move_o === 1'b1) move_cnt++;
      if (bus.frame_valid_o === 1'b1) valid_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench time limit");
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_line(input int which, input logic v);
      case (which)
         P_WIN:  bus.window_start_i = v;
         P_HAM:  bus.hamming_done_i = v;
         P_FFT:  bus.fft_done_i     = v;
         P_MEL:  bus.mel_done_i     = v;
         P_DCT:  bus.dct_done_i     = v;
         P_STOP: bus.stop_i         = v;
         default: bus.clear_i       = v;
      endcase
   endtask

   task automatic pulse(input int which);
      set_line(which, 1'b1);
      step(1);
      set_line(which, 1'b0);
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_status(input string tag, input logic [2:0] st, input logic busy,
                               input logic idle, input logic err, input logic valid);
      check({tag, ".state"}, bus.state_o, st);
      check({tag, ".busy"},  bus.busy_o,  busy);
      check({tag, ".idle"},  bus.idle_o,  idle);
      check({tag, ".error"}, bus.error_o, err);
      check({tag, ".valid"}, bus.frame_valid_o, valid);
   endtask

   task automatic check_reset_values(input string tag);
      check_status(tag, ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
      check({tag, ".start_move"},  bus.start_move_o, 1'b0);
      check({tag, ".frame_count"}, bus.frame_count_o, 16'd0);
   endtask

   task automatic expect_accept(input string tag);
      model_cnt++;
      exp_q.push_back(16'(model_cnt));
      check({tag, ".frame_count"}, bus.frame_count_o, exp_q.pop_front());
      check({tag, ".valid_drop"},  bus.frame_valid_o, 1'b0);
   endtask

   // One frame from WAIT_WIN; stall > 0 holds out_ready_i low for that many OUTPUT cycles.
   task automatic run_frame(input string tag, input int stall);
      pulse(P_WIN);
      check({tag, ".hamming"}, bus.state_o, ST_HAMMING);
      step(2);
      pulse(P_HAM);
      check({tag, ".fft"}, bus.state_o, ST_FFT);
      step(2);
      pulse(P_FFT);
      step(2);
      pulse(P_MEL);
      step(2);
      bus.out_ready_i = (stall == 0);
      pulse(P_DCT);
      check_status({tag, ".output"}, ST_OUTPUT, 1'b1, 1'b0, 1'b0, 1'b1);
      if (stall > 0) begin
         step(stall - 1);
         check_status({tag, ".stalled"}, ST_OUTPUT, 1'b1, 1'b0, 1'b0, 1'b1);
         bus.out_ready_i = 1'b1;
      end
      step(1);
      expect_accept(tag);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      bus.enable_i = 1'b0;
      bus.stop_i = 1'b0;
      bus.clear_i = 1'b0;
      bus.window_start_i = 1'b0;
      bus.hamming_done_i = 1'b0;
      bus.fft_done_i = 1'b0;
      bus.mel_done_i = 1'b0;
      bus.dct_done_i = 1'b0;
      bus.out_ready_i = 1'b0;

      step(2);
      check_reset_values("por");

      // single frame, stages 10 cycles apart
      rst_n = 1'b1;
      bus.enable_i = 1'b1;
      bus.out_ready_i = 1'b1;
      step(1);
      check_status("t1.wait", ST_WAIT_WIN, 1'b0, 1'b0, 1'b0, 1'b0);
      base = move_cnt;
      pulse(P_WIN);
      check_status("t1.hamming", ST_HAMMING, 1'b1, 1'b0, 1'b0, 1'b0);
      step(9);
      pulse(P_HAM);
      check("t1.fft", bus.state_o, ST_FFT);
      check("t1.move_hi", bus.start_move_o, 1'b1);
      step(1);
      check("t1.move_lo", bus.start_move_o, 1'b0);
      step(8);
      pulse(P_FFT);
      check("t1.mel", bus.state_o, ST_MEL);
      step(9);
      pulse(P_MEL);
      check("t1.dct", bus.state_o, ST_DCT);
      step(9);
      pulse(P_DCT);
      check_status("t1.output", ST_OUTPUT, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1);
      expect_accept("t1");
      check_status("t1.back", ST_WAIT_WIN, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t1.move_count", move_cnt - base, 1);

      // reset held for 3 cycles while in MEL
      pulse(P_WIN);
      step(1);
      pulse(P_HAM);
      step(1);
      pulse(P_FFT);
      check("t6.in_mel", bus.state_o, ST_MEL);
      rst_n = 1'b0;
      #1;
      check_reset_values("t6.async");
      step(3);
      check_reset_values("t6.held");
      model_cnt = 0;
      exp_q.delete();
      rst_n = 1'b1;
      step(1);
      check("t6.wait", bus.state_o, ST_WAIT_WIN);

      // three back-to-back frames, frame 2 stalled 50 cycles
      run_frame("t2.f1", 0);
      check("t2.f1.wait", bus.state_o, ST_WAIT_WIN);
      base = valid_cnt;
      run_frame("t2.f2", 50);
      check("t2.f2.valid_cycles", valid_cnt - base, 50);
      check("t2.f2.wait", bus.state_o, ST_WAIT_WIN);
      run_frame("t2.f3", 0);
      check("t2.final_count", bus.frame_count_o, 16'd3);
      check("t2.no_error", bus.error_o, 1'b0);

      // stop during FFT: frame completes, then IDLE
      pulse(P_WIN);
      step(2);
      pulse(P_HAM);
      pulse(P_STOP);
      check("t3.still_fft", bus.state_o, ST_FFT);
      step(1);
      pulse(P_FFT);
      step(2);
      pulse(P_MEL);
      step(2);
      pulse(P_DCT);
      check("t3.output", bus.state_o, ST_OUTPUT);
      step(1);
      expect_accept("t3");
      check_status("t3.idle", ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.enable_i = 1'b0;
      pulse(P_WIN);
      step(3);
      check_status("t3.win_ignored", ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.enable_i = 1'b1;
      step(1);
      check("t3.reenable", bus.state_o, ST_WAIT_WIN);
      step(2);
      check("t3.stop_cleared", bus.state_o, ST_WAIT_WIN);

      // FFT timeout after exactly TO cycles, then clear
      pulse(P_WIN);
      step(2);
      pulse(P_HAM);
      step(TO - 1);
      check_status("t4.last_fft", ST_FFT, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      check_status("t4.error", ST_ERROR, 1'b0, 1'b0, 1'b1, 1'b0);
      step(5);
      check("t4.sticky", bus.error_o, 1'b1);
      pulse(P_CLR);
      check_status("t4.cleared", ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t4.count_kept", bus.frame_count_o, 16'd4);
      step(1);
      check("t4.wait", bus.state_o, ST_WAIT_WIN);
      pulse(P_CLR);
      check("t4.clear_ignored", bus.state_o, ST_WAIT_WIN);
      pulse(P_DCT);
      check("t4.done_ignored", bus.state_o, ST_WAIT_WIN);

      // mel_done while in HAMMING
      base = move_cnt;
      pulse(P_WIN);
      step(3);
      pulse(P_MEL);
      check_status("t5.error", ST_ERROR, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t5.no_move", bus.start_move_o, 1'b0);
      step(3);
      check("t5.move_count", move_cnt - base, 0);
      pulse(P_CLR);
      step(1);
      check("t5.wait", bus.state_o, ST_WAIT_WIN);

      // simultaneous dones with the expected one present
      pulse(P_WIN);
      bus.hamming_done_i = 1'b1;
      bus.fft_done_i = 1'b1;
      step(1);
      bus.hamming_done_i = 1'b0;
      bus.fft_done_i = 1'b0;
      check_status("t7.fft", ST_FFT, 1'b1, 1'b0, 1'b0, 1'b0);
      bus.fft_done_i = 1'b1;
      bus.dct_done_i = 1'b1;
      step(1);
      bus.fft_done_i = 1'b0;
      bus.dct_done_i = 1'b0;
      check_status("t7.mel", ST_MEL, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
